// File: rtl/instr_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM encoding,
// instruction field positions and PC helpers.
package instr_fetch_stage_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RD_MSB  = 25;
  localparam int unsigned RD_LSB  = 21;
  localparam int unsigned RS_MSB  = 20;
  localparam int unsigned RS_LSB  = 16;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } fetch_state_t;

  // Branch targets are word aligned; the low two bits are dropped silently.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Bus bundle between the fetch stage and its environment: instruction memory
// request/ack, branch redirect and the packet handshake towards decode.
interface instr_fetch_stage_if;
  import instr_fetch_stage_pkg::*;

  logic               imem_req;
  logic [INSTR_W-1:0] imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               redirect;
  logic [INSTR_W-1:0] redirect_pc;

  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_pc;
  logic [5:0]         id_opcode;
  logic [4:0]         id_rd;
  logic [4:0]         id_rs;
  logic [15:0]        id_imm16;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc,
    output id_valid, id_pc, id_opcode, id_rd, id_rs, id_imm16,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc,
    input  id_valid, id_pc, id_opcode, id_rd, id_rs, id_imm16,
    output id_ready
  );

endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time and
// buffers a single decoded-field packet for decode. Redirects squash in-flight work.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  instr_fetch_stage_if.master bus
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  req_addr;
  logic         squash;

  logic [31:0]  redirect_target;
  logic [31:0]  pc_next_seq;

  assign redirect_target = align_pc(bus.redirect_pc);
  assign pc_next_seq     = pc + 32'(PC_STEP);
  assign bus.imem_addr   = req_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StIdle;
      pc            <= RESET_PC;
      req_addr      <= '0;
      squash        <= 1'b0;
      bus.imem_req  <= 1'b0;
      bus.id_valid  <= 1'b0;
      bus.id_pc     <= '0;
      bus.id_opcode <= '0;
      bus.id_rd     <= '0;
      bus.id_rs     <= '0;
      bus.id_imm16  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          state        <= StFetch;
          bus.imem_req <= 1'b1;
          if (bus.redirect) begin
            pc       <= redirect_target;
            req_addr <= redirect_target;
          end else begin
            req_addr <= pc;
          end
        end

        StFetch: begin
          if (bus.redirect && bus.imem_ack) begin
            // The returning word is from the old path; restart at the target now.
            pc       <= redirect_target;
            req_addr <= redirect_target;
            squash   <= 1'b0;
          end else if (bus.redirect) begin
            // Address must stay put until the outstanding fetch completes.
            pc     <= redirect_target;
            squash <= 1'b1;
          end else if (bus.imem_ack && squash) begin
            squash   <= 1'b0;
            req_addr <= pc;
          end else if (bus.imem_ack) begin
            bus.id_opcode <= bus.imem_rdata[OPC_MSB:OPC_LSB];
            bus.id_rd     <= bus.imem_rdata[RD_MSB:RD_LSB];
            bus.id_rs     <= bus.imem_rdata[RS_MSB:RS_LSB];
            bus.id_imm16  <= bus.imem_rdata[IMM_MSB:IMM_LSB];
            bus.id_pc     <= req_addr;
            bus.id_valid  <= 1'b1;
            pc            <= pc_next_seq;
            state         <= StHold;
            bus.imem_req  <= 1'b0;
          end
        end

        StHold: begin
          if (bus.redirect) begin
            bus.id_valid <= 1'b0;
            pc           <= redirect_target;
            req_addr     <= redirect_target;
            state        <= StFetch;
            bus.imem_req <= 1'b1;
          end else if (bus.id_ready) begin
            bus.id_valid <= 1'b0;
            req_addr     <= pc;
            state        <= StFetch;
            bus.imem_req <= 1'b1;
          end
        end

        default: begin
          state        <= StIdle;
          bus.imem_req <= 1'b0;
          bus.id_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios, a wrap-around instance and a
// randomized run checked against a packet-stream reference model.
module tb_instr_fetch_stage;

  logic clk = 1'b0;
  logic rst_n_a = 1'b1;
  logic rst_n_b = 1'b1;

  always #5 clk = ~clk;

  instr_fetch_stage_if bus_a ();
  instr_fetch_stage_if bus_b ();

  instr_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (bus_a)
  );

  instr_fetch_stage #(
    .RESET_PC (32'hFFFF_FFFC),
    .PC_STEP  (4)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bus_b)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h8C22_FFFC;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pkt_a(input string tag, input logic [31:0] pc, input logic [31:0] w);
    check({tag, "_valid"}, 32'(bus_a.id_valid), 32'd1);
    check({tag, "_pc"}, bus_a.id_pc, pc);
    check({tag, "_fields"},
          {bus_a.id_opcode, bus_a.id_rd, bus_a.id_rs, bus_a.id_imm16}, w);
  endtask

  // Random-phase bookkeeping
  logic [31:0] exp_pc;
  logic [31:0] rpc;
  logic        p_req, p_ack, p_valid, p_ready, p_redir;
  logic [31:0] p_addr, p_pc, p_fields;
  logic        have_prev;
  int          wait_cnt;
  int          idle;
  logic        ack, redir, ready;

  initial begin
    bus_a.imem_ack = 1'b0; bus_a.imem_rdata = '0; bus_a.redirect = 1'b0;
    bus_a.redirect_pc = '0; bus_a.id_ready = 1'b0;
    bus_b.imem_ack = 1'b0; bus_b.imem_rdata = '0; bus_b.redirect = 1'b0;
    bus_b.redirect_pc = '0; bus_b.id_ready = 1'b0;

    #1 rst_n_a = 1'b0; rst_n_b = 1'b0;
    #2;
    check("rst_req", 32'(bus_a.imem_req), 32'd0);
    check("rst_addr", bus_a.imem_addr, 32'd0);
    check("rst_valid", 32'(bus_a.id_valid), 32'd0);
    check("rst_pkt", {bus_a.id_opcode, bus_a.id_rd, bus_a.id_rs, bus_a.id_imm16}, 32'd0);
    check("rst_idpc", bus_a.id_pc, 32'd0);

    // Test 1: first fetch, ack two cycles after the request rises
    step();
    #3 rst_n_a = 1'b1;
    step();
    check("t1_req", 32'(bus_a.imem_req), 32'd1);
    check("t1_addr", bus_a.imem_addr, 32'd0);
    step();
    bus_a.imem_ack = 1'b1; bus_a.imem_rdata = 32'h8C22_FFFC;
    step();
    bus_a.imem_ack = 1'b0;
    check_pkt_a("t1", 32'd0, {6'h23, 5'd1, 5'd2, 16'hFFFC});
    check("t1_req_off", 32'(bus_a.imem_req), 32'd0);

    // Test 2: backpressure holds the packet and keeps the bus quiet
    for (int i = 0; i < 5; i++) begin
      step();
      check_pkt_a("t2_hold", 32'd0, 32'h8C22_FFFC);
      check("t2_noreq", 32'(bus_a.imem_req), 32'd0);
    end
    bus_a.id_ready = 1'b1;
    step();
    bus_a.id_ready = 1'b0;
    check("t2_req", 32'(bus_a.imem_req), 32'd1);
    check("t2_addr", bus_a.imem_addr, 32'd4);
    check("t2_valid", 32'(bus_a.id_valid), 32'd0);

    // Test 3: redirect while the fetch of 8 is outstanding
    bus_a.imem_ack = 1'b1; bus_a.imem_rdata = mem_word(32'd4);
    step();
    bus_a.imem_ack = 1'b0;
    check_pkt_a("t3_p4", 32'd4, mem_word(32'd4));
    bus_a.id_ready = 1'b1;
    step();
    bus_a.id_ready = 1'b0;
    check("t3_addr8", bus_a.imem_addr, 32'd8);
    bus_a.redirect = 1'b1; bus_a.redirect_pc = 32'h100;
    step();
    bus_a.redirect = 1'b0;
    check("t3_stable1", bus_a.imem_addr, 32'd8);
    step();
    check("t3_stable2", bus_a.imem_addr, 32'd8);
    bus_a.imem_ack = 1'b1; bus_a.imem_rdata = mem_word(32'd8);
    step();
    bus_a.imem_ack = 1'b0;
    check("t3_dropped", 32'(bus_a.id_valid), 32'd0);
    check("t3_req", 32'(bus_a.imem_req), 32'd1);
    check("t3_addr100", bus_a.imem_addr, 32'h100);
    bus_a.imem_ack = 1'b1; bus_a.imem_rdata = mem_word(32'h100);
    step();
    bus_a.imem_ack = 1'b0;
    check_pkt_a("t3_p100", 32'h100, mem_word(32'h100));

    // Test 4: redirect coincident with ack
    bus_a.id_ready = 1'b1;
    step();
    bus_a.id_ready = 1'b0;
    check("t4_addr104", bus_a.imem_addr, 32'h104);
    bus_a.imem_ack = 1'b1; bus_a.imem_rdata = mem_word(32'h104);
    bus_a.redirect = 1'b1; bus_a.redirect_pc = 32'h203;
    step();
    bus_a.imem_ack = 1'b0; bus_a.redirect = 1'b0;
    check("t4_dropped", 32'(bus_a.id_valid), 32'd0);
    check("t4_req", 32'(bus_a.imem_req), 32'd1);
    check("t4_addr200", bus_a.imem_addr, 32'h200);

    // Test 5: redirect in HOLD wins over a same-cycle id_ready
    bus_a.imem_ack = 1'b1; bus_a.imem_rdata = mem_word(32'h200);
    step();
    bus_a.imem_ack = 1'b0;
    check_pkt_a("t5_p200", 32'h200, mem_word(32'h200));
    bus_a.redirect = 1'b1; bus_a.redirect_pc = 32'h200; bus_a.id_ready = 1'b1;
    step();
    bus_a.redirect = 1'b0; bus_a.id_ready = 1'b0;
    check("t5_valid_fall", 32'(bus_a.id_valid), 32'd0);
    check("t5_req", 32'(bus_a.imem_req), 32'd1);
    check("t5_addr", bus_a.imem_addr, 32'h200);
    step();
    check("t5_no_repres", 32'(bus_a.id_valid), 32'd0);

    // Test 6: wrap-around instance and asynchronous reset mid-fetch
    #3 rst_n_b = 1'b1;
    step();
    check("t6_addr0", bus_b.imem_addr, 32'hFFFF_FFFC);
    bus_b.imem_ack = 1'b1; bus_b.imem_rdata = mem_word(32'hFFFF_FFFC);
    step();
    bus_b.imem_ack = 1'b0;
    check("t6_pc", bus_b.id_pc, 32'hFFFF_FFFC);
    bus_b.id_ready = 1'b1;
    step();
    bus_b.id_ready = 1'b0;
    check("t6_wrap_addr", bus_b.imem_addr, 32'd0);
    check("t6_wrap_req", 32'(bus_b.imem_req), 32'd1);
    step();
    #2 rst_n_b = 1'b0;
    #1;
    check("t6_rst_req", 32'(bus_b.imem_req), 32'd0);
    check("t6_rst_addr", bus_b.imem_addr, 32'd0);
    check("t6_rst_idpc", bus_b.id_pc, 32'd0);
    bus_b.imem_ack = 1'b1; bus_b.imem_rdata = 32'hDEAD_BEEF;
    step();
    check("t6_ack_in_rst", 32'(bus_b.id_valid), 32'd0);
    #3 rst_n_b = 1'b1;
    step();
    bus_b.imem_ack = 1'b0;
    check("t6_late_ack_valid", 32'(bus_b.id_valid), 32'd0);
    check("t6_restart_addr", bus_b.imem_addr, 32'hFFFF_FFFC);
    check("t6_restart_req", 32'(bus_b.imem_req), 32'd1);

    // Randomized run on instance A against the packet-stream model
    rst_n_a = 1'b0;
    bus_a.imem_ack = 1'b0; bus_a.redirect = 1'b0; bus_a.id_ready = 1'b0;
    step();
    #3 rst_n_a = 1'b1;
    step();
    exp_pc = 32'h0;
    have_prev = 1'b0;
    wait_cnt = -1;
    idle = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (have_prev && p_req && !p_ack) begin
        check("r_req_hold", 32'(bus_a.imem_req), 32'd1);
        check("r_addr_hold", bus_a.imem_addr, p_addr);
      end
      if (have_prev && p_valid && !p_ready && !p_redir) begin
        check("r_pkt_valid_hold", 32'(bus_a.id_valid), 32'd1);
        check("r_pkt_pc_hold", bus_a.id_pc, p_pc);
        check("r_pkt_fields_hold",
              {bus_a.id_opcode, bus_a.id_rd, bus_a.id_rs, bus_a.id_imm16}, p_fields);
      end

      ack = 1'b0;
      if (bus_a.imem_req) begin
        if (wait_cnt < 0) wait_cnt = int'($urandom_range(0, 3));
        if (wait_cnt == 0) begin
          ack = 1'b1;
          wait_cnt = -1;
        end else begin
          wait_cnt--;
        end
      end else begin
        wait_cnt = -1;
        ack = ($urandom_range(0, 7) == 0);
      end
      redir = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      ready = ($urandom_range(0, 1) == 1);

      bus_a.imem_ack    = ack;
      bus_a.imem_rdata  = bus_a.imem_req ? mem_word(bus_a.imem_addr) : $urandom;
      bus_a.redirect    = redir;
      bus_a.redirect_pc = rpc;
      bus_a.id_ready    = ready;

      if (bus_a.id_valid && ready && !redir) begin
        check("r_accept_pc", bus_a.id_pc, exp_pc);
        check("r_accept_fields",
              {bus_a.id_opcode, bus_a.id_rd, bus_a.id_rs, bus_a.id_imm16}, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        idle = 0;
      end
      if (redir) begin
        exp_pc = rpc & 32'hFFFF_FFFC;
        idle = 0;
      end else begin
        idle++;
      end
      if (idle > 60) begin
        check("r_progress", 32'(idle), 32'd0);
        idle = 0;
      end

      p_req     = bus_a.imem_req;
      p_ack     = ack;
      p_addr    = bus_a.imem_addr;
      p_valid   = bus_a.id_valid;
      p_ready   = ready;
      p_redir   = redir;
      p_pc      = bus_a.id_pc;
      p_fields  = {bus_a.id_opcode, bus_a.id_rd, bus_a.id_rs, bus_a.id_imm16};
      have_prev = 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
